filterbank_trim_ctrl: RTL and testbench

// - Digital trim controller for a bank of N_STAGE gyrator filter stages. Holds per-stage shunt- and

---
 rtl/filt_pkg.sv | 25 ++
 rtl/trim_sar_fsm.sv | 107 ++++++++++
 rtl/filterbank_trim_ctrl.sv | 93 +++++++++
 tb/tb_filterbank_trim_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/filt_pkg.sv
// Shared definitions for the filter-bank trim controller: code defaults,
// register-file entry encoding and the SAR engine state enum.
package filt_pkg;

   localparam int CODE_W_DEF     = 6;
   localparam int RESET_CODE_DEF = 32;

   // Entry select within a stage: entry = 2*stage + sel
   localparam logic SEL_SHUNT  = 1'b0;
   localparam logic SEL_SERIES = 1'b1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SET    = 3'd1,
      SETTLE = 3'd2,
      DECIDE = 3'd3,
      DONE   = 3'd4
   } sar_state_e;

   // Flat register-file index of a stage's shunt or series gyrator code
   function automatic int entry_idx(input int stage, input logic sel);
      return 2 * stage + int'(sel);
   endfunction

endpackage

// File: rtl/trim_sar_fsm.sv
// SAR auto-tune engine: binary-searches the replica trim code MSB first,
// waiting a fixed settle time after each trial code before sampling the
// comparator. Emits a one-cycle result_valid alongside cal_done.
module trim_sar_fsm
   import filt_pkg::*;
#(
   parameter int CODE_W     = CODE_W_DEF,
   parameter int SETTLE_CYC = 16,
   parameter int RESET_CODE = RESET_CODE_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              cmp,
   output logic              busy,
   output logic              done,
   output logic              result_valid,
   output logic [CODE_W-1:0] code,
   output logic [CODE_W-1:0] result
);

   localparam int KW = $clog2(CODE_W);
   localparam int CW = $clog2(SETTLE_CYC + 1);
   localparam logic [CODE_W-1:0] RST_VAL = CODE_W'(RESET_CODE);
   localparam logic [CODE_W-1:0] ONE     = {{(CODE_W-1){1'b0}}, 1'b1};
   localparam logic [CODE_W-1:0] TOP_BIT = {1'b1, {(CODE_W-1){1'b0}}};

   sar_state_e        state_r;
   logic [KW-1:0]     bit_r;
   logic [CW-1:0]     cnt_r;
   logic [CODE_W-1:0] result_r;
   logic [CODE_W-1:0] mask_s;
   logic [CODE_W-1:0] kept_s;

   assign result = result_r;

   // Trial decision: a high comparator means the code is too high, so drop bit k
   always_comb begin
      mask_s = ONE << bit_r;
      if (cmp) begin
         kept_s = code & ~mask_s;
      end else begin
         kept_s = code;
      end
   end

   // SAR sequencer with registered busy/done/code outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         bit_r        <= {KW{1'b0}};
         cnt_r        <= {CW{1'b0}};
         result_r     <= {CODE_W{1'b0}};
         code         <= RST_VAL;
         busy         <= 1'b0;
         done         <= 1'b0;
         result_valid <= 1'b0;
      end else begin
         done         <= 1'b0;
         result_valid <= 1'b0;
         case (state_r)
            IDLE: begin
               if (start) begin
                  state_r  <= SET;
                  result_r <= {CODE_W{1'b0}};
                  bit_r    <= KW'(CODE_W - 1);
                  code     <= TOP_BIT;
                  busy     <= 1'b1;
               end
            end
            SET: begin
               cnt_r   <= CW'(SETTLE_CYC - 1);
               state_r <= SETTLE;
            end
            SETTLE: begin
               if (cnt_r == {CW{1'b0}}) begin
                  state_r <= DECIDE;
               end else begin
                  cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
               end
            end
            DECIDE: begin
               result_r <= kept_s;
               if (bit_r == {KW{1'b0}}) begin
                  state_r      <= DONE;
                  code         <= kept_s;
                  busy         <= 1'b0;
                  done         <= 1'b1;
                  result_valid <= 1'b1;
               end else begin
                  bit_r   <= bit_r - {{(KW-1){1'b0}}, 1'b1};
                  code    <= kept_s | (mask_s >> 1);
                  state_r <= SET;
               end
            end
            DONE: begin
               state_r <= IDLE;
            end
            default: begin
               state_r <= IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/filterbank_trim_ctrl.sv
// Trim controller for a bank of gyrator filter stages: shadow/active code
// register pairs, atomic commit, and SAR calibration broadcast to all stages.
module filterbank_trim_ctrl
   import filt_pkg::*;
#(
   parameter int N_STAGE     = 4,
   parameter int CODE_W      = CODE_W_DEF,
   parameter int SETTLE_CYC  = 16,
   parameter int RESET_CODE  = RESET_CODE_DEF,
   parameter int AUTO_COMMIT = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         wr_en,
   input  logic [$clog2(2*N_STAGE)-1:0] wr_addr,
   input  logic [CODE_W-1:0]            wr_data,
   input  logic                         commit,
   input  logic                         cal_start,
   input  logic                         cal_cmp,
   output logic                         cal_busy,
   output logic                         cal_done,
   output logic [CODE_W-1:0]            cal_code,
   output logic [N_STAGE*CODE_W-1:0]    trim_shunt,
   output logic [N_STAGE*CODE_W-1:0]    trim_series
);

   localparam int N_ENT = 2 * N_STAGE;
   localparam logic [CODE_W-1:0] RST_VAL = CODE_W'(RESET_CODE);

   logic [CODE_W-1:0] shadow_r [N_ENT];
   logic [CODE_W-1:0] active_r [N_ENT];
   logic              result_valid_s;
   logic [CODE_W-1:0] result_s;
   logic              wr_ok_s;
   logic              commit_ok_s;

   trim_sar_fsm #(
      .CODE_W     (CODE_W),
      .SETTLE_CYC (SETTLE_CYC),
      .RESET_CODE (RESET_CODE)
   ) u_sar (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (cal_start),
      .cmp          (cal_cmp),
      .busy         (cal_busy),
      .done         (cal_done),
      .result_valid (result_valid_s),
      .code         (cal_code),
      .result       (result_s)
   );

   // Host accesses are dropped while calibration owns the register file
   always_comb begin
      wr_ok_s     = 1'b0;
      commit_ok_s = 1'b0;
      if (!cal_busy) begin
         wr_ok_s     = wr_en && (32'(wr_addr) < 32'(N_ENT));
         commit_ok_s = commit;
      end else begin
         wr_ok_s     = 1'b0;
         commit_ok_s = 1'b0;
      end
   end

   // Shadow file: calibration broadcast wins over a host write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int e = 0; e < N_ENT; e++) shadow_r[e] <= RST_VAL;
      end else if (result_valid_s) begin
         for (int e = 0; e < N_ENT; e++) shadow_r[e] <= result_s;
      end else if (wr_ok_s) begin
         shadow_r[wr_addr] <= wr_data;
      end
   end

   // Active file: atomic copy of the pre-write shadow on commit, or the cal result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int e = 0; e < N_ENT; e++) active_r[e] <= RST_VAL;
      end else if (result_valid_s && (AUTO_COMMIT != 0)) begin
         for (int e = 0; e < N_ENT; e++) active_r[e] <= result_s;
      end else if (commit_ok_s) begin
         active_r <= shadow_r;
      end
   end

   for (genvar i = 0; i < N_STAGE; i++) begin : g_pack
      assign trim_shunt[i*CODE_W +: CODE_W]  = active_r[entry_idx(i, SEL_SHUNT)];
      assign trim_series[i*CODE_W +: CODE_W] = active_r[entry_idx(i, SEL_SERIES)];
   end

endmodule

// File: tb/tb_filterbank_trim_ctrl.sv
// Self-checking bench for filterbank_trim_ctrl with default parameters.
module tb_filterbank_trim_ctrl;

   localparam int N    = 4;
   localparam int W    = 6;
   localparam int S    = 16;
   localparam int SLOT = S + 2;
   localparam int LAT  = W * SLOT + 1;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           wr_en;
   logic [2:0]     wr_addr;
   logic [W-1:0]   wr_data;
   logic           commit;
   logic           cal_start;
   logic           cal_cmp;
   logic           cal_busy;
   logic           cal_done;
   logic [W-1:0]   cal_code;
   logic [N*W-1:0] trim_shunt;
   logic [N*W-1:0] trim_series;

   int n_checks = 0;
   int n_errors = 0;
   int cmp_mode = 0;
   int thr      = 0;

   logic [W-1:0] m_shadow [2*N];
   logic [W-1:0] m_active [2*N];

   filterbank_trim_ctrl #(
      .N_STAGE(N), .CODE_W(W), .SETTLE_CYC(S), .RESET_CODE(32), .AUTO_COMMIT(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .commit(commit), .cal_start(cal_start), .cal_cmp(cal_cmp), .cal_busy(cal_busy),
      .cal_done(cal_done), .cal_code(cal_code), .trim_shunt(trim_shunt), .trim_series(trim_series)
   );

   always #5 clk = ~clk;

   function automatic logic cmp_fn(input int mode, input int t, input int c);
      if (mode == 0) return (c > t);
      else if (mode == 1) return 1'b1;
      else return 1'b0;
   endfunction

   // Replica comparator model
   always_comb cal_cmp = cmp_fn(cmp_mode, thr, int'(cal_code));

   // Expected calibration result: largest code the comparator does not reject
   function automatic int ref_result(input int mode, input int t);
      int best = 0;
      for (int c = 0; c < (1 << W); c++) if (!cmp_fn(mode, t, c)) best = c;
      return best;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      for (int i = 0; i < N; i++) begin
         check($sformatf("%s shunt%0d", tag, i), 64'(trim_shunt[i*W +: W]), 64'(m_active[2*i]));
         check($sformatf("%s series%0d", tag, i), 64'(trim_series[i*W +: W]), 64'(m_active[2*i+1]));
      end
   endtask

   task automatic model_reset();
      for (int e = 0; e < 2*N; e++) begin
         m_shadow[e] = 6'd32;
         m_active[e] = 6'd32;
      end
   endtask

   // One calibration run, cycle-numbered from the cycle after cal_start is sampled
   task automatic run_cal(input int mode, input int t, input bit inject);
      int pulses = 0;
      int done_cyc = -1;
      int r = 0;
      int trial;
      int exp_res;
      cmp_mode = mode;
      thr      = t;
      exp_res  = ref_result(mode, t);
      cal_start = 1'b1;
      for (int c = 1; c <= LAT + 40; c++) begin
         @(negedge clk);
         cal_start = 1'b0;
         wr_en     = 1'b0;
         commit    = 1'b0;
         check($sformatf("busy c%0d", c), 64'(cal_busy), 64'((c >= 1) && (c < LAT)));
         if (cal_done) begin
            pulses++;
            if (done_cyc < 0) done_cyc = c;
         end
         if (((c - 1) % SLOT == 0) && ((c - 1) / SLOT < W)) begin
            trial = r | (1 << (W - 1 - (c - 1) / SLOT));
            check($sformatf("trial c%0d", c), 64'(cal_code), 64'(trial));
            if (!cmp_fn(mode, t, trial)) r = trial;
         end
         if (c == LAT) check("final code", 64'(cal_code), 64'(exp_res));
         if (c == 50) check_all("locked");
         if (c == LAT + 1) begin
            for (int e = 0; e < 2*N; e++) begin
               m_shadow[e] = W'(exp_res);
               m_active[e] = W'(exp_res);
            end
            check_all("broadcast");
            check("code hold", 64'(cal_code), 64'(exp_res));
         end
         if (inject && c == 30) begin
            wr_en = 1'b1; wr_addr = 3'd2; wr_data = 6'h11;
         end
         if (inject && c == 40) commit = 1'b1;
         if (inject && c == 60) cal_start = 1'b1;
      end
      check("done pulses", 64'(pulses), 64'd1);
      check("done cycle", 64'(done_cyc), 64'(LAT));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 6'd0;
      commit = 1'b0; cal_start = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check_all("reset");
      check("reset code", 64'(cal_code), 64'd32);
      check("reset busy", 64'(cal_busy), 64'd0);
      check("reset done", 64'(cal_done), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check_all("post reset");

      // Shadow write without commit leaves active untouched
      wr_en = 1'b1; wr_addr = 3'd3; wr_data = 6'h15;
      @(negedge clk);
      wr_en = 1'b0;
      m_shadow[3] = 6'h15;
      check_all("no commit");
      commit = 1'b1;
      @(negedge clk);
      commit = 1'b0;
      m_active = m_shadow;
      check_all("commit");

      // Write and commit together: commit sees the old shadow value
      wr_en = 1'b1; wr_addr = 3'd0; wr_data = 6'h07; commit = 1'b1;
      @(negedge clk);
      wr_en = 1'b0; commit = 1'b0;
      m_active = m_shadow;
      m_shadow[0] = 6'h07;
      check_all("wr+commit");
      commit = 1'b1;
      @(negedge clk);
      commit = 1'b0;
      m_active = m_shadow;
      check_all("second commit");

      // Random host traffic
      for (int n = 0; n < 24; n++) begin
         wr_en   = 1'($urandom_range(0, 1));
         wr_addr = 3'($urandom_range(0, 7));
         wr_data = 6'($urandom_range(0, 63));
         commit  = ($urandom_range(0, 3) == 0);
         @(negedge clk);
         if (commit) m_active = m_shadow;
         if (wr_en) m_shadow[wr_addr] = wr_data;
         check_all("rand");
      end
      wr_en = 1'b0; commit = 1'b0;
      wr_en = 1'b1; wr_addr = 3'd2; wr_data = 6'h3C;
      @(negedge clk);
      wr_en = 1'b0;
      m_shadow[2] = 6'h3C;

      // Calibration: threshold with busy lockout, extremes, random thresholds
      run_cal(0, 32'h2A, 1'b1);
      run_cal(1, 0, 1'b0);
      run_cal(2, 0, 1'b0);
      for (int k = 0; k < 3; k++) run_cal(0, int'($urandom_range(0, 63)), 1'b0);

      // Reset in the middle of a calibration
      cmp_mode = 0; thr = 20;
      cal_start = 1'b1;
      for (int c = 1; c <= 50; c++) begin
         @(negedge clk);
         cal_start = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all("mid reset");
      check("mid reset code", 64'(cal_code), 64'd32);
      check("mid reset busy", 64'(cal_busy), 64'd0);
      check("mid reset done", 64'(cal_done), 64'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 80; c++) begin
         @(negedge clk);
         check("no done after reset", 64'(cal_done), 64'd0);
         check("no busy after reset", 64'(cal_busy), 64'd0);
      end
      check_all("after reset");
      run_cal(0, int'($urandom_range(0, 63)), 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
